// File: rtl/yukle_sakla_birimi.sv
// Load/store initiator for a 32-bit word-addressed data memory (async read, sync write).
// Latency accept->response: load 2, word store 2, sub-word store 3 (read-modify-write), error 1.
// Backpressure: hazir_o is high only when idle; the response is a one-cycle pulse and cannot be stalled.
module yukle_sakla_birimi #(
  parameter int BELLEK_ADRES_BIT = 11
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        istek_i,
  output logic        hazir_o,
  input  logic        yaz_i,
  input  logic [1:0]  boyut_i,
  input  logic        isaretsiz_i,
  input  logic [31:0] adres_i,
  input  logic [31:0] veri_i,
  output logic        gecerli_o,
  output logic [31:0] veri_o,
  output logic        hata_o,
  output logic        bellek_wen_o,
  output logic [31:0] bellek_adres_o,
  output logic [31:0] bellek_veri_o,
  input  logic [31:0] bellek_veri_i
);

  localparam logic [1:0] BOSTA = 2'd0;
  localparam logic [1:0] OKU   = 2'd1;
  localparam logic [1:0] YAZ   = 2'd2;
  localparam logic [1:0] YANIT = 2'd3;

  localparam logic [1:0] BOYUT_BAYT  = 2'b00;
  localparam logic [1:0] BOYUT_YARIM = 2'b01;
  localparam logic [1:0] BOYUT_KELIME = 2'b10;

  logic [1:0]  durum_q, durum_d;
  logic        yaz_q;
  logic [1:0]  boyut_q;
  logic        isaretsiz_q;
  logic [31:0] adres_q;
  logic [31:0] veri_q;
  logic [31:0] eski_q;
  logic [31:0] sonuc_q, sonuc_d;
  logic        hata_q, hata_d;

  logic        kabul;
  logic        istek_hatasi;
  logic [4:0]  bayt_kayma;
  logic [4:0]  yarim_kayma;
  logic [31:0] okunan_kayik;
  logic [31:0] yuklenen;
  logic [31:0] yazma_verisi;

  assign hazir_o = (durum_q == BOSTA);
  assign kabul   = istek_i && hazir_o;

  // Request legality, evaluated on the raw inputs so the decision is made at accept.
  always_comb begin
    istek_hatasi = 1'b0;
    case (boyut_i)
      BOYUT_YARIM:  istek_hatasi = adres_i[0];
      BOYUT_KELIME: istek_hatasi = (adres_i[1:0] != 2'b00);
      BOYUT_BAYT:   istek_hatasi = 1'b0;
      default:      istek_hatasi = 1'b1;
    endcase
    if (|adres_i[31:BELLEK_ADRES_BIT]) begin
      istek_hatasi = 1'b1;
    end
  end

  // Lane offsets: byte lane is adr[1:0], half lane is adr[1].
  assign bayt_kayma   = {adres_q[1:0], 3'b000};
  assign yarim_kayma  = {adres_q[1], 4'b0000};
  assign okunan_kayik = (boyut_q == BOYUT_BAYT) ? (bellek_veri_i >> bayt_kayma)
                                                : (bellek_veri_i >> yarim_kayma);

  // Load result: selected lane, sign- or zero-extended.
  always_comb begin
    yuklenen = bellek_veri_i;
    case (boyut_q)
      BOYUT_BAYT:  yuklenen = {{24{~isaretsiz_q & okunan_kayik[7]}}, okunan_kayik[7:0]};
      BOYUT_YARIM: yuklenen = {{16{~isaretsiz_q & okunan_kayik[15]}}, okunan_kayik[15:0]};
      default:     yuklenen = bellek_veri_i;
    endcase
  end

  // Write data: whole word for word stores, otherwise the old word with one lane replaced.
  always_comb begin
    yazma_verisi = veri_q;
    case (boyut_q)
      BOYUT_BAYT:  yazma_verisi = (eski_q & ~(32'h0000_00FF << bayt_kayma))
                                | ((veri_q & 32'h0000_00FF) << bayt_kayma);
      BOYUT_YARIM: yazma_verisi = (eski_q & ~(32'h0000_FFFF << yarim_kayma))
                                | ((veri_q & 32'h0000_FFFF) << yarim_kayma);
      default:     yazma_verisi = veri_q;
    endcase
  end

  // Next state plus the response data/error that are captured on entry to YANIT.
  always_comb begin
    durum_d = durum_q;
    sonuc_d = sonuc_q;
    hata_d  = hata_q;
    case (durum_q)
      BOSTA: begin
        if (kabul) begin
          if (istek_hatasi) begin
            durum_d = YANIT;
            sonuc_d = 32'd0;
            hata_d  = 1'b1;
          end else begin
            hata_d = 1'b0;
            if (yaz_i && (boyut_i == BOYUT_KELIME)) begin
              durum_d = YAZ;
            end else begin
              durum_d = OKU;
            end
          end
        end
      end
      OKU: begin
        if (yaz_q) begin
          durum_d = YAZ;
        end else begin
          durum_d = YANIT;
          sonuc_d = yuklenen;
        end
      end
      YAZ: begin
        durum_d = YANIT;
        sonuc_d = 32'd0;
      end
      default: begin
        durum_d = BOSTA;
      end
    endcase
  end

  // State and response registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      durum_q <= BOSTA;
      sonuc_q <= 32'd0;
      hata_q  <= 1'b0;
    end else begin
      durum_q <= durum_d;
      sonuc_q <= sonuc_d;
      hata_q  <= hata_d;
    end
  end

  // Request fields are captured once at accept and held for the whole transaction.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      yaz_q       <= 1'b0;
      boyut_q     <= 2'b00;
      isaretsiz_q <= 1'b0;
      adres_q     <= 32'd0;
      veri_q      <= 32'd0;
    end else if (kabul) begin
      yaz_q       <= yaz_i;
      boyut_q     <= boyut_i;
      isaretsiz_q <= isaretsiz_i;
      adres_q     <= adres_i;
      veri_q      <= veri_i;
    end
  end

  // Old word captured during OKU so the merge in YAZ does not depend on the read path.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      eski_q <= 32'd0;
    end else if (durum_q == OKU) begin
      eski_q <= bellek_veri_i;
    end
  end

  assign gecerli_o      = (durum_q == YANIT);
  assign hata_o         = (durum_q == YANIT) && hata_q;
  assign veri_o         = sonuc_q;
  assign bellek_wen_o   = (durum_q == YAZ);
  assign bellek_adres_o = {adres_q[31:2], 2'b00};
  assign bellek_veri_o  = yazma_verisi;

endmodule

// File: tb/tb_yukle_sakla_birimi.sv
// Bench for yukle_sakla_birimi: directed spec cases, an async reset abort, then random traffic.
// Expected responses come from a byte-array memory model and are queued at accept time.
// A monitor pops and compares on every response, including latency and write-enable count.
module tb_yukle_sakla_birimi;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        istek_i;
  logic        hazir_o;
  logic        yaz_i;
  logic [1:0]  boyut_i;
  logic        isaretsiz_i;
  logic [31:0] adres_i;
  logic [31:0] veri_i;
  logic        gecerli_o;
  logic [31:0] veri_o;
  logic        hata_o;
  logic        bellek_wen_o;
  logic [31:0] bellek_adres_o;
  logic [31:0] bellek_veri_o;
  logic [31:0] bellek_veri_i;

  always #5 clk_i = ~clk_i;

  yukle_sakla_birimi #(.BELLEK_ADRES_BIT(11)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .istek_i(istek_i), .hazir_o(hazir_o),
    .yaz_i(yaz_i), .boyut_i(boyut_i), .isaretsiz_i(isaretsiz_i),
    .adres_i(adres_i), .veri_i(veri_i), .gecerli_o(gecerli_o), .veri_o(veri_o),
    .hata_o(hata_o), .bellek_wen_o(bellek_wen_o), .bellek_adres_o(bellek_adres_o),
    .bellek_veri_o(bellek_veri_o), .bellek_veri_i(bellek_veri_i)
  );

  // Data memory seen by the DUT: async read, sync full-word write.
  logic [31:0] mem [0:511];
  assign bellek_veri_i = mem[bellek_adres_o[10:2]];
  always @(posedge clk_i) begin
    if (bellek_wen_o) mem[bellek_adres_o[10:2]] <= bellek_veri_o;
  end

  // Reference memory as little-endian bytes.
  logic [7:0] ref_b [0:2047];

  typedef struct {
    logic [31:0] veri;
    logic        hata;
    int          cyc;
    int          wen;
  } beklenen_t;

  beklenen_t kuyruk[$];
  beklenen_t mon_e;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int wen_cnt = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string ad, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", ad, got, exp);
    end
  endtask

  // Behavioural model: decides error, result, latency and memory effect from the request alone.
  task automatic model(input logic yaz, input logic [1:0] boyut, input logic isz,
                       input logic [31:0] adr, input logic [31:0] veri, input int acc);
    beklenen_t e;
    int n;
    int a;
    logic [31:0] val;
    bit err;
    err = (boyut == 2'd3) || (boyut == 2'd1 && adr[0]) ||
          (boyut == 2'd2 && adr[1:0] != 2'b00) || (adr >= 32'h800);
    if (err) begin
      e = '{veri: 32'd0, hata: 1'b1, cyc: acc + 1, wen: 0};
    end else begin
      n = 1 << boyut;
      a = int'(adr[10:0]);
      if (!yaz) begin
        val = 32'd0;
        for (int i = 0; i < n; i++) val = val | (32'(ref_b[a + i]) << (8 * i));
        if (n < 4 && !isz && val[8 * n - 1]) val = val | (32'hFFFF_FFFF << (8 * n));
        e = '{veri: val, hata: 1'b0, cyc: acc + 2, wen: 0};
      end else begin
        for (int i = 0; i < n; i++) ref_b[a + i] = 8'(veri >> (8 * i));
        e = '{veri: 32'd0, hata: 1'b0, cyc: acc + ((n == 4) ? 2 : 3), wen: 1};
      end
    end
    kuyruk.push_back(e);
  endtask

  task automatic istek(input logic yaz, input logic [1:0] boyut, input logic isz,
                       input logic [31:0] adr, input logic [31:0] veri);
    int bekle = 0;
    @(negedge clk_i);
    yaz_i = yaz; boyut_i = boyut; isaretsiz_i = isz; adres_i = adr; veri_i = veri;
    istek_i = 1'b1;
    while (!hazir_o && bekle < 50) begin
      @(negedge clk_i);
      bekle++;
    end
    if (!hazir_o) begin
      checks++; failures++;
      $display("FAIL hazir_timeout got=0 expected=1");
      istek_i = 1'b0;
      return;
    end
    model(yaz, boyut, isz, adr, veri, cyc);
    @(posedge clk_i);
    #1 istek_i = 1'b0;
    veri_i = $urandom;
  endtask

  task automatic bosalt();
    int bekle = 0;
    while (kuyruk.size() != 0 && bekle < 200) begin
      @(negedge clk_i);
      bekle++;
    end
    checks++;
    if (kuyruk.size() != 0) begin
      failures++;
      $display("FAIL response_timeout got=%0d pending expected=0", kuyruk.size());
      kuyruk.delete();
    end
  endtask

  // Monitor: every response must match the oldest queued expectation.
  initial begin
    forever begin
      @(negedge clk_i);
      if (rst_ni !== 1'b1) begin
        wen_cnt = 0;
      end else begin
        if (bellek_wen_o) wen_cnt++;
        if (gecerli_o) begin
          if (kuyruk.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_response got=gecerli_o=1 expected=none");
          end else begin
            mon_e = kuyruk.pop_front();
            check("veri_o", veri_o, mon_e.veri);
            check("hata_o", {31'd0, hata_o}, {31'd0, mon_e.hata});
            check("latency_cycle", cyc, mon_e.cyc);
            check("wen_cycles", wen_cnt, mon_e.wen);
          end
          wen_cnt = 0;
        end
      end
    end
  end

  logic [31:0] snap;
  logic [31:0] w;
  int mism;
  logic [31:0] radr;

  initial begin
    rst_ni = 1'b0; istek_i = 1'b0; yaz_i = 1'b0; boyut_i = 2'd0; isaretsiz_i = 1'b0;
    adres_i = 32'd0; veri_i = 32'd0;
    for (int i = 0; i < 512; i++) begin
      w = (i == 4) ? 32'h8765_4321 : $urandom;
      mem[i] = w;
      for (int b = 0; b < 4; b++) ref_b[4 * i + b] = 8'(w >> (8 * b));
    end
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("reset_hazir", {31'd0, hazir_o}, 32'd1);
    check("reset_gecerli", {31'd0, gecerli_o}, 32'd0);
    check("reset_hata", {31'd0, hata_o}, 32'd0);
    check("reset_veri_o", veri_o, 32'd0);
    check("reset_wen", {31'd0, bellek_wen_o}, 32'd0);
    rst_ni = 1'b1;

    istek(1'b0, 2'd0, 1'b0, 32'h13, 32'd0);
    istek(1'b0, 2'd0, 1'b1, 32'h13, 32'd0);
    istek(1'b0, 2'd1, 1'b0, 32'h10, 32'd0);
    istek(1'b0, 2'd1, 1'b0, 32'h12, 32'd0);
    istek(1'b1, 2'd1, 1'b0, 32'h12, 32'h0000_BEEF);
    istek(1'b0, 2'd2, 1'b0, 32'h10, 32'd0);
    istek(1'b1, 2'd2, 1'b0, 32'h20, 32'hCAFE_BABE);
    istek(1'b0, 2'd2, 1'b0, 32'h20, 32'd0);
    istek(1'b1, 2'd2, 1'b0, 32'h16, 32'h1111_2222);
    istek(1'b0, 2'd1, 1'b0, 32'h11, 32'd0);
    istek(1'b0, 2'd3, 1'b0, 32'h10, 32'd0);
    istek(1'b0, 2'd2, 1'b0, 32'h800, 32'd0);
    bosalt();
    check("mem_0x10_after_half_store", mem[4], 32'hBEEF_4321);
    check("mem_0x20_after_word_store", mem[8], 32'hCAFE_BABE);

    // Reset during YAZ of a byte store: the write must be abandoned with no response.
    snap = mem[4];
    @(negedge clk_i);
    while (!hazir_o) @(negedge clk_i);
    yaz_i = 1'b1; boyut_i = 2'd0; adres_i = 32'h10; veri_i = 32'h0000_005A; istek_i = 1'b1;
    @(posedge clk_i);
    #1 istek_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    check("abort_wen_in_yaz", {31'd0, bellek_wen_o}, 32'd1);
    #1 rst_ni = 1'b0;
    #1 check("abort_wen_dropped", {31'd0, bellek_wen_o}, 32'd0);
    check("abort_no_gecerli", {31'd0, gecerli_o}, 32'd0);
    @(posedge clk_i);
    @(negedge clk_i);
    check("abort_mem_unchanged", mem[4], snap);
    rst_ni = 1'b1;
    @(negedge clk_i);
    check("abort_hazir_after_release", {31'd0, hazir_o}, 32'd1);
    check("abort_veri_o_cleared", veri_o, 32'd0);

    for (int k = 0; k < 300; k++) begin
      case ($urandom_range(0, 9))
        0:       radr = 32'h800 + $urandom_range(0, 255);
        1:       radr = $urandom;
        default: radr = $urandom_range(0, 63);
      endcase
      istek(1'($urandom), 2'($urandom), 1'($urandom), radr, $urandom);
    end
    bosalt();

    mism = 0;
    for (int i = 0; i < 512; i++) begin
      if (mem[i] !== {ref_b[4 * i + 3], ref_b[4 * i + 2], ref_b[4 * i + 1], ref_b[4 * i]})
        mism++;
    end
    check("final_memory_mismatch_words", mism, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
